// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the multicycle RV32I control FSM and its datapath.
// Latency: none, wires only.
// Backpressure: the mem_ready input stalls the FSM in its memory states.
interface multicycle_control_fsm_if;
  logic [6:0] opcode;
  logic       mem_ready;
  logic       branch_cond;
  logic [1:0] alu_op;
  logic       is_imm;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] result_src;
  logic       adr_src;
  logic       ir_write;
  logic       reg_write;
  logic       mem_write;
  logic       pc_write;
  logic       retire;
  logic       illegal;
  logic [3:0] state;

  // Control FSM side: reads IR opcode and status, drives datapath controls.
  modport master (
    input  opcode, mem_ready, branch_cond,
    output alu_op, is_imm, alu_src_a, alu_src_b, result_src, adr_src,
           ir_write, reg_write, mem_write, pc_write, retire, illegal, state
  );

  // Datapath side: supplies opcode and status, consumes controls.
  modport slave (
    output opcode, mem_ready, branch_cond,
    input  alu_op, is_imm, alu_src_a, alu_src_b, result_src, adr_src,
           ir_write, reg_write, mem_write, pc_write, retire, illegal, state
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Main control FSM of the multicycle RV32I core: FETCH/DECODE/EXECUTE/MEM/WB sequencing.
// Latency: Moore outputs per state; 3-5 cycles per instruction without stalls.
// Backpressure: FETCH/MEMREAD/MEMWRITE hold while mem_ready=0 (when MEM_WAIT=1).
module multicycle_control_fsm #(
  parameter bit MEM_WAIT       = 1'b1,
  parameter bit ILLEGAL_STICKY = 1'b1
) (
  input  logic                     clk,
  input  logic                     resetn,
  multicycle_control_fsm_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEMADR    = 4'd2,
    S_MEMREAD   = 4'd3,
    S_MEMWB     = 4'd4,
    S_MEMWRITE  = 4'd5,
    S_EXEC_R    = 4'd6,
    S_EXEC_I    = 4'd7,
    S_ALUWB     = 4'd8,
    S_BRANCH    = 4'd9,
    S_JAL       = 4'd10,
    S_JALR      = 4'd11,
    S_JALR_LINK = 4'd12,
    S_LUI       = 4'd13,
    S_AUIPC     = 4'd14,
    S_ILLEGAL   = 4'd15
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  state_t state_q, state_d;

  // With MEM_WAIT=0 the memory is assumed to complete every access in one cycle.
  logic mem_rdy;
  assign mem_rdy = MEM_WAIT ? bus.mem_ready : 1'b1;

  logic [1:0] alu_op, alu_src_a, alu_src_b, result_src;
  logic       is_imm, adr_src, ir_write, reg_write, mem_write;
  logic       pc_update, branch, retire, illegal;

  // State register; an async reset drops straight back to FETCH, aborting any access.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= S_FETCH;
    else         state_q <= state_d;
  end

  // Next-state and Moore output decode; every control defaults to inactive.
  always_comb begin
    state_d    = state_q;
    alu_op     = 2'b00;
    is_imm     = 1'b0;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    result_src = 2'b00;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    mem_write  = 1'b0;
    pc_update  = 1'b0;
    branch     = 1'b0;
    retire     = 1'b0;
    illegal    = 1'b0;

    case (state_q)
      S_FETCH: begin
        // PC+4 is computed while instruction memory answers; latch only when it does.
        alu_src_b = 2'b10;
        ir_write  = mem_rdy;
        pc_update = mem_rdy;
        if (mem_rdy) state_d = S_DECODE;
      end
      S_DECODE: begin
        // oldPC+imm precomputed into ALUOut for branch/JAL targets.
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (bus.opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_R:              state_d = S_EXEC_R;
          OP_I:              state_d = S_EXEC_I;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR;
          OP_LUI:            state_d = S_LUI;
          OP_AUIPC:          state_d = S_AUIPC;
          default:           state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        // opcode[5] separates store (0100011) from load (0000011).
        state_d   = bus.opcode[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        if (mem_rdy) state_d = S_MEMWB;
      end
      S_MEMWRITE: begin
        // The store request stays up until memory accepts it; that cycle ends the instruction.
        adr_src   = 1'b1;
        mem_write = 1'b1;
        retire    = mem_rdy;
        if (mem_rdy) state_d = S_FETCH;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_EXEC_R: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end
      S_EXEC_I: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
        is_imm    = 1'b1;
        state_d   = S_ALUWB;
      end
      S_LUI: begin
        alu_src_a = 2'b11;
        alu_src_b = 2'b01;
        state_d   = S_ALUWB;
      end
      S_AUIPC: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        // ALU compares rs1/rs2 while ALUOut still holds the target from DECODE.
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        branch    = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_JAL: begin
        // Jump to ALUOut target while the ALU forms the link value oldPC+4.
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_update = 1'b1;
        state_d   = S_ALUWB;
      end
      S_JALR: begin
        // rs1+imm goes straight to PC; the link is formed in the next state.
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        result_src = 2'b10;
        pc_update  = 1'b1;
        state_d    = S_JALR_LINK;
      end
      S_JALR_LINK: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        state_d   = S_ALUWB;
      end
      S_ILLEGAL: begin
        illegal = 1'b1;
        state_d = ILLEGAL_STICKY ? S_ILLEGAL : S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  assign bus.alu_op     = alu_op;
  assign bus.is_imm     = is_imm;
  assign bus.alu_src_a  = alu_src_a;
  assign bus.alu_src_b  = alu_src_b;
  assign bus.result_src = result_src;
  assign bus.adr_src    = adr_src;
  assign bus.ir_write   = ir_write;
  assign bus.reg_write  = reg_write;
  assign bus.mem_write  = mem_write;
  assign bus.pc_write   = pc_update | (branch & bus.branch_cond);
  assign bus.retire     = retire;
  assign bus.illegal    = illegal;
  assign bus.state      = state_q;

endmodule
